// File: rtl/dmem_defs.sv
// Shared definitions for the data-memory responder: FSM encodings and widths.
package dmem_defs;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM.
module dmem_ram
  import dmem_defs::*;
#(
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write: a same-cycle write does not appear on rdata until the next read.
  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    rdata_q <= mem[index];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake, programmable wait states, internal RAM.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_defs::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oor_q, oor_d;
    logic              mis_q, mis_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              rd_live_q, rd_live_d;
    logic              rd_zero_q, rd_zero_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              cur_we, cur_oor, cur_mis, to_resp;
    logic [AW-1:0]     cur_idx;
    logic [DATA_W-1:0] cur_wdata, ram_rdata, rd_value;

    // In IDLE the request is taken straight from the inputs so a zero-wait
    // transfer can hit the RAM on its accept edge; afterwards the captured copy is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = we;
            cur_idx   = addr[AW+1:2];
            cur_wdata = wdata;
            cur_oor   = |addr[DATA_W-1:AW+2];
            cur_mis   = ALIGN_CHECK & (|addr[1:0]);
        end else begin
            cur_we    = we_q;
            cur_idx   = idx_q;
            cur_wdata = wdata_q;
            cur_oor   = oor_q;
            cur_mis   = mis_q;
        end
    end

    assign rd_value = rd_zero_q ? '0 : ram_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        oor_d     = oor_q;
        mis_d     = mis_q;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        rd_zero_d = rd_zero_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rd_live_d = 1'b0;
        to_resp   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = cur_we;
                    idx_d   = cur_idx;
                    wdata_d = cur_wdata;
                    oor_d   = cur_oor;
                    mis_d   = cur_mis;
                    cnt_d   = WAIT_INIT;
                    busy_d  = 1'b1;
                    if (WAIT_INIT == '0) begin
                        to_resp = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    to_resp = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (rd_live_q) rdata_d = rd_value;
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_resp) begin
            ack_d     = 1'b1;
            err_d     = cur_mis;
            rd_live_d = ~cur_we;
            rd_zero_d = cur_oor | cur_mis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            oor_q     <= 1'b0;
            mis_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_live_q <= 1'b0;
            rd_zero_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            oor_q     <= oor_d;
            mis_q     <= mis_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            rd_live_q <= rd_live_d;
            rd_zero_q <= rd_zero_d;
            rdata_q   <= rdata_d;
        end
    end

    dmem_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (to_resp & cur_we & ~cur_oor & ~cur_mis),
        .index (cur_idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // During the ack cycle the RAM output is shown live; rdata_q then holds it.
    assign rdata = rd_live_q ? rd_value : rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule
